// File: rtl/aes_128_dec_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_dec_iter_if
// Purpose  : Handshake bundle for the iterative AES-128 decryptor.
//            Input side carries key + ciphertext (valid/ready), output side
//            carries plaintext + cache-hit flag (valid/ready).
// Modports : slave  - the decryptor (consumes in_*, produces out_*)
//            master - the block driving it
// Revision : 1.0 - initial release
// ============================================================================
interface aes_128_dec_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_ct;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_pt;
  logic         out_key_hit;

  modport slave (
    input  in_valid, in_key, in_ct, out_ready,
    output in_ready, out_valid, out_pt, out_key_hit
  );

  modport master (
    output in_valid, in_key, in_ct, out_ready,
    input  in_ready, out_valid, out_pt, out_key_hit
  );
endinterface
`default_nettype wire

// File: rtl/aes_128_dec_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_dec_iter
// Purpose  : Iterative AES-128 inverse cipher, one round per clock. Round
//            keys are produced on the fly by the inverse key schedule; the
//            last round key (rk10) of the most recent key is cached so a
//            repeated key skips the 10-cycle forward expansion.
// Ports    : clk, rst (async, active-high)
//            bus.in_valid/in_ready/in_key/in_ct   - key + ciphertext in
//            bus.out_valid/out_ready/out_pt       - plaintext out
//            bus.out_key_hit                      - op used cached rk10
// Params   : NR (must be 10), CACHE_EN (1 = rk10 cache enabled)
// Revision : 1.0 - initial release
// ============================================================================
module aes_128_dec_iter #(
  parameter int NR       = 10,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  aes_128_dec_iter_if.slave  bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_KEXP = 2'd1;
  localparam logic [1:0] c_DEC  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [3:0] c_NR = NR[3:0];

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] c_INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    return c_SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] f_inv_sbox(input logic [7:0] x);
    return c_INV_SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] f_rcon(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] f_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] m11[4];
    logic [7:0] m13[4];
    logic [7:0] m14[4];
    for (int i = 0; i < 4; i++) begin
      a      = col[31-8*i -: 8];
      x2     = f_xt(a);
      x4     = f_xt(x2);
      x8     = f_xt(x4);
      m9[i]  = x8 ^ a;
      m11[i] = x8 ^ x2 ^ a;
      m13[i] = x8 ^ x4 ^ a;
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  logic [1:0]   r_fsm;
  logic [3:0]   r_cnt;        // expansion step in KEXP, round index in DEC
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [127:0] r_ct;
  logic [127:0] r_key;
  logic [127:0] r_cache_key;
  logic [127:0] r_cache_rk10;
  logic         r_cache_valid;
  logic         r_out_valid;
  logic [127:0] r_out_pt;
  logic         r_hit;

  logic         w_hit;
  logic [31:0]  w_w3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sw;
  logic [31:0]  w_t;
  logic [3:0]   w_rcon_idx;
  logic [127:0] w_rk_fwd;
  logic [127:0] w_rk_inv;
  logic [127:0] w_isb;
  logic [127:0] w_addk;
  logic [127:0] w_imc;

  assign w_hit = CACHE_EN && r_cache_valid && (bus.in_key == r_cache_key);

  // One SubWord serves both schedules: forward expansion rotates the old
  // w3, inverse expansion rotates the recovered w3 (= w3' ^ w2').
  assign w_w3       = (r_fsm == c_KEXP) ? r_rk[31:0] : (r_rk[31:0] ^ r_rk[63:32]);
  assign w_rcon_idx = (r_fsm == c_KEXP) ? r_cnt : (r_cnt + 4'd1);
  assign w_rot      = {w_w3[23:0], w_w3[31:24]};
  assign w_t        = w_sw ^ {f_rcon(w_rcon_idx), 24'h0};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    assign w_sw[31-8*i -: 8] = f_sbox(w_rot[31-8*i -: 8]);
  end

  always_comb begin
    w_rk_fwd[127:96] = r_rk[127:96] ^ w_t;
    w_rk_fwd[95:64]  = r_rk[95:64]  ^ w_rk_fwd[127:96];
    w_rk_fwd[63:32]  = r_rk[63:32]  ^ w_rk_fwd[95:64];
    w_rk_fwd[31:0]   = r_rk[31:0]   ^ w_rk_fwd[63:32];
  end

  assign w_rk_inv = {r_rk[127:96] ^ w_t,
                     r_rk[95:64]  ^ r_rk[127:96],
                     r_rk[63:32]  ^ r_rk[95:64],
                     r_rk[31:0]   ^ r_rk[63:32]};

  // InvShiftRows + InvSubBytes: byte (row r, col c) comes from col (c - r) mod 4.
  for (genvar b = 0; b < 16; b++) begin : g_inv_sub_shift
    localparam int c_ROW = b % 4;
    localparam int c_COL = b / 4;
    localparam int c_SRC = c_ROW + 4 * ((c_COL - c_ROW + 4) % 4);
    assign w_isb[127-8*b -: 8] = f_inv_sbox(r_state[127-8*c_SRC -: 8]);
  end

  assign w_addk = w_isb ^ w_rk_inv;

  for (genvar c = 0; c < 4; c++) begin : g_inv_mix
    assign w_imc[127-32*c -: 32] = f_inv_mix_col(w_addk[127-32*c -: 32]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm         <= c_IDLE;
      r_cnt         <= 4'd0;
      r_state       <= 128'h0;
      r_rk          <= 128'h0;
      r_ct          <= 128'h0;
      r_key         <= 128'h0;
      r_cache_key   <= 128'h0;
      r_cache_rk10  <= 128'h0;
      r_cache_valid <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_pt      <= 128'h0;
      r_hit         <= 1'b0;
    end else begin
      case (r_fsm)
        c_IDLE: begin
          if (bus.in_valid) begin
            r_ct  <= bus.in_ct;
            r_key <= bus.in_key;
            if (w_hit) begin
              r_state <= bus.in_ct ^ r_cache_rk10;
              r_rk    <= r_cache_rk10;
              r_cnt   <= c_NR - 4'd1;
              r_hit   <= 1'b1;
              r_fsm   <= c_DEC;
            end else begin
              r_rk  <= bus.in_key;
              r_cnt <= 4'd1;
              r_hit <= 1'b0;
              r_fsm <= c_KEXP;
            end
          end
        end
        c_KEXP: begin
          r_rk <= w_rk_fwd;
          if (r_cnt == c_NR) begin
            r_cache_key   <= r_key;
            r_cache_rk10  <= w_rk_fwd;
            r_cache_valid <= 1'b1;
            r_state       <= r_ct ^ w_rk_fwd;
            r_cnt         <= c_NR - 4'd1;
            r_fsm         <= c_DEC;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_DEC: begin
          r_rk <= w_rk_inv;
          if (r_cnt == 4'd0) begin
            // Final round has no InvMixColumns.
            r_out_pt    <= w_addk;
            r_out_valid <= 1'b1;
            r_fsm       <= c_DONE;
          end else begin
            r_state <= w_imc;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        c_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_fsm       <= c_IDLE;
          end
        end
        default: r_fsm <= c_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_fsm == c_IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.out_pt      = r_out_pt;
  assign bus.out_key_hit = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_dec_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_128_dec_iter
// Purpose  : Self-checking bench for aes_128_dec_iter. Two instances are
//            built (cache on / cache off); a select steers stimulus to one.
//            Expected plaintext, hit flag and latency are queued when an
//            operation is issued and compared when the result appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_128_dec_iter;

  localparam logic [127:0] c_K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_K2 = 128'he4dc18adf3d05ec9e4dcc41acb990007;
  localparam logic [127:0] c_C2 = 128'hd225406f484809186cb5d86be4098445;
  localparam logic [127:0] c_P2 = 128'h4072da1240f930f7d3c8cf8b9322042e;
  localparam logic [127:0] c_C3 = 128'hccbf51af8e0bbc46283481a211e9c77b;
  localparam logic [127:0] c_P3 = 128'h110687e2636afdb84c12653d55f3bae1;

  logic         clk;
  logic         rst;
  logic         sel;          // 0: cached instance, 1: uncached instance
  logic         in_valid;
  logic [127:0] in_key;
  logic [127:0] in_ct;
  logic         out_ready;

  logic         w_in_ready;
  logic         w_out_valid;
  logic [127:0] w_out_pt;
  logic         w_out_key_hit;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [127:0] exp_pt_q[$];
  bit           exp_hit_q[$];
  int           exp_lat_q[$];
  int           acc_q[$];

  aes_128_dec_iter_if bus_c();
  aes_128_dec_iter_if bus_n();

  assign bus_c.in_valid  = in_valid & ~sel;
  assign bus_c.in_key    = in_key;
  assign bus_c.in_ct     = in_ct;
  assign bus_c.out_ready = out_ready & ~sel;
  assign bus_n.in_valid  = in_valid & sel;
  assign bus_n.in_key    = in_key;
  assign bus_n.in_ct     = in_ct;
  assign bus_n.out_ready = out_ready & sel;

  assign w_in_ready    = sel ? bus_n.in_ready    : bus_c.in_ready;
  assign w_out_valid   = sel ? bus_n.out_valid   : bus_c.out_valid;
  assign w_out_pt      = sel ? bus_n.out_pt      : bus_c.out_pt;
  assign w_out_key_hit = sel ? bus_n.out_key_hit : bus_c.out_key_hit;

  aes_128_dec_iter #(.NR(10), .CACHE_EN(1'b1)) u_dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
  );

  aes_128_dec_iter #(.NR(10), .CACHE_EN(1'b0)) u_dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation. cyc at a negedge equals the index of the last
  // posedge, so the accepting edge is cyc+1.
  task automatic send(input logic [127:0] key, input logic [127:0] ct,
                      input logic [127:0] pt, input bit hit, input int lat,
                      input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!w_in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required=1", w_in_ready);
    end
    in_key   = key;
    in_ct    = ct;
    in_valid = 1'b1;
    if (track) begin
      exp_pt_q.push_back(pt);
      exp_hit_q.push_back(hit);
      exp_lat_q.push_back(lat);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard side: wait for a result, compare it against the oldest
  // queued expectation, optionally stall the consumer, then accept it.
  task automatic receive(input string name, input int hold);
    int           n;
    logic [127:0] ept;
    bit           ehit;
    int           elat;
    int           acc;
    n = 0;
    while (!w_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    ept  = exp_pt_q.pop_front();
    ehit = exp_hit_q.pop_front();
    elat = exp_lat_q.pop_front();
    acc  = acc_q.pop_front();
    checks++;
    if (w_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required=1", name, w_out_valid);
    end else begin
      checks++;
      if (w_out_pt !== ept) begin
        errors++;
        $display("FAIL %s_pt: got %h required %h", name, w_out_pt, ept);
      end
      checks++;
      if (w_out_key_hit !== ehit) begin
        errors++;
        $display("FAIL %s_hit: got %b required %b", name, w_out_key_hit, ehit);
      end
      checks++;
      if (cyc - acc != elat) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", name, cyc - acc, elat);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (w_out_valid !== 1'b1 || w_out_pt !== ept || w_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_hold: valid=%b pt=%h in_ready=%b required valid=1 pt=%h in_ready=0",
                   name, w_out_valid, w_out_pt, w_in_ready, ept);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 and 1",
                 name, w_out_valid, w_in_ready);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (w_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b required 0", w_out_valid);
    end
    checks++;
    if (w_out_pt !== 128'h0) begin
      errors++;
      $display("FAIL reset_out_pt: got %h required 0", w_out_pt);
    end
    checks++;
    if (w_out_key_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_hit: got %b required 0", w_out_key_hit);
    end
    checks++;
    if (w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", w_in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips_c1();
    send(c_K1, c_C1, c_P1, 1'b0, 20, 1'b1);
    receive("fips_c1", 0);
  endtask

  task automatic test_cache_hit();
    send(c_K2, c_C2, c_P2, 1'b0, 20, 1'b1);
    receive("key2_miss", 0);
    send(c_K2, c_C3, c_P3, 1'b1, 10, 1'b1);
    receive("key2_hit", 0);
  endtask

  task automatic test_backpressure();
    send(c_K2, c_C2, c_P2, 1'b1, 10, 1'b1);
    receive("backpressure", 7);
  endtask

  task automatic test_reset_mid();
    // Key 1 misses (cache holds key 2); abort inside the expansion.
    send(c_K1, c_C1, c_P1, 1'b0, 20, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (w_out_valid !== 1'b0 || w_out_pt !== 128'h0 || w_out_key_hit !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b pt=%h hit=%b required all 0",
               w_out_valid, w_out_pt, w_out_key_hit);
    end
    checks++;
    if (w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_ready: got %b required 1", w_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    send(c_K2, c_C3, c_P3, 1'b0, 20, 1'b1);
    receive("after_reset_miss", 0);
  endtask

  task automatic test_no_cache();
    sel = 1'b1;
    send(c_K2, c_C2, c_P2, 1'b0, 20, 1'b1);
    receive("nocache_first", 0);
    send(c_K2, c_C3, c_P3, 1'b0, 20, 1'b1);
    receive("nocache_second", 0);
    sel = 1'b0;
  endtask

  task automatic test_busy_ignore();
    send(c_K2, c_C2, c_P2, 1'b1, 10, 1'b1);
    // Offer a different key throughout DEC and DONE.
    in_key   = c_K1;
    in_ct    = c_C1;
    in_valid = 1'b1;
    receive("busy_current", 0);
    // Back in IDLE with in_valid still high: accepted on the next edge.
    exp_pt_q.push_back(c_P1);
    exp_hit_q.push_back(1'b0);
    exp_lat_q.push_back(20);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    receive("busy_next_miss", 0);
    // The key change overwrote the cache with key 1.
    send(c_K1, c_C1, c_P1, 1'b1, 10, 1'b1);
    receive("key1_hit", 0);
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_key    = 128'h0;
    in_ct     = 128'h0;
    out_ready = 1'b0;
    test_reset();
    test_fips_c1();
    test_cache_hit();
    test_backpressure();
    test_reset_mid();
    test_no_cache();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
